// File: rtl/gdiv_pkg.sv
// ---------------------------------------------------------------------------
// gdiv_pkg
// Shared types and constants for the Goldschmidt divider (goldschmidt_div).
//   gdiv_state_t   : controller states IDLE / MUL_N / MUL_D / DONE
//   GDIV_IT_W      : width of the refinement iteration counter
//   GDIV_ITERS_MIN : smallest supported ITERS value
//   GDIV_ITERS_MAX : largest supported ITERS value (fits GDIV_IT_W bits)
//   gdiv_iters_ok(): range check for an ITERS value
// ---------------------------------------------------------------------------
package gdiv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL_N = 2'd1,
      MUL_D = 2'd2,
      DONE  = 2'd3
   } gdiv_state_t;

   localparam int GDIV_IT_W      = 4;
   localparam int GDIV_ITERS_MIN = 1;
   localparam int GDIV_ITERS_MAX = (1 << GDIV_IT_W) - 1;

   function automatic bit gdiv_iters_ok(input int iters);
      return (iters >= GDIV_ITERS_MIN) && (iters <= GDIV_ITERS_MAX);
   endfunction

endpackage

// File: rtl/gdiv_fxmul.sv
// ---------------------------------------------------------------------------
// gdiv_fxmul
// Combinational unsigned Q1.(WIDTH-1) x Q1.(WIDTH-1) -> Q1.(WIDTH-1)
// multiplier used by the Goldschmidt divider.  The full 2*WIDTH product is
// re-aligned by dropping WIDTH-1 fraction bits; any result >= 2.0 saturates
// to all-ones.
//
// Build option:
//   GDIV_ROUND_EN defined   : round to nearest (add the first dropped bit
//                             before slicing; saturation checked afterwards)
//   GDIV_ROUND_EN undefined : truncate
//
// Ports:
//   a  input  WIDTH  multiplicand, Q1.(WIDTH-1)
//   b  input  WIDTH  multiplier,   Q1.(WIDTH-1)
//   y  output WIDTH  product,      Q1.(WIDTH-1), saturated
// ---------------------------------------------------------------------------
module gdiv_fxmul
   import gdiv_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     aligned;

   // Align the Q2.(2*WIDTH-2) product back to Q1.(WIDTH-1).  The extra top
   // bit of the return value carries a rounding overflow into saturation.
   function automatic logic [WIDTH:0] fx_align(input logic [2*WIDTH-1:0] p);
      logic [WIDTH:0] s;
`ifdef GDIV_ROUND_EN
      s = {1'b0, p[2*WIDTH-2:WIDTH-1]} + {{WIDTH{1'b0}}, p[WIDTH-2]};
`else
      s = {1'b0, p[2*WIDTH-2:WIDTH-1]};
`endif
      return s;
   endfunction

   // Clamp to the largest representable value when the integer part of the
   // product (or the rounded result) reached 2.0.
   function automatic logic [WIDTH-1:0] fx_sat(input logic [WIDTH:0] s,
                                               input logic        ovf);
      return (ovf || s[WIDTH]) ? {WIDTH{1'b1}} : s[WIDTH-1:0];
   endfunction

   assign prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   assign aligned = fx_align(prod);
   assign y       = fx_sat(aligned, prod[2*WIDTH-1]);

endmodule

// File: rtl/goldschmidt_div.sv
// ---------------------------------------------------------------------------
// goldschmidt_div
// Self-sequencing Goldschmidt divider: q = n / d for normalised unsigned
// Q1.(WIDTH-1) operands, starting from a caller-supplied reciprocal seed
// K0 ~= 1/d.  Each refinement iteration takes two cycles on one shared
// multiplier (gdiv_fxmul): N <= N*K, then D <= D*K and K <= 2 - D.
// After ITERS+1 such pairs the quotient is N.
//
// Build option: GDIV_ROUND_EN selects round-to-nearest in gdiv_fxmul
// (default build truncates).
//
// Parameters:
//   WIDTH  operand/result width (Q1.(WIDTH-1))
//   ITERS  refinement iterations after the seed scaling, 1..15
//
// Ports:
//   clk    input   1      rising-edge clock
//   reset  input   1      asynchronous active-low reset
//   start  input   1      divide request, taken only while ready=1
//   n_in   input   WIDTH  dividend, [1,2)
//   d_in   input   WIDTH  divisor, [1,2) (MSB must be set)
//   ia_in  input   WIDTH  reciprocal seed, (0.5,1]
//   clear  input   1      synchronous abort back to IDLE, no done pulse
//   ready  output  1      high while IDLE
//   done   output  1      one-cycle pulse when q_out/err are updated
//   q_out  output  WIDTH  quotient, held until the next result
//   err    output  1      divisor was not normalised; held with q_out
// ---------------------------------------------------------------------------
module goldschmidt_div
   import gdiv_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int ITERS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] n_in,
   input  logic [WIDTH-1:0] d_in,
   input  logic [WIDTH-1:0] ia_in,
   input  logic             clear,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] q_out,
   output logic             err
);

   // Q1.(WIDTH-1) representation of 1.0; a divisor below it is rejected.
   localparam logic [WIDTH-1:0]     ONE     = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [GDIV_IT_W-1:0] IT_LAST = GDIV_IT_W'(ITERS);

   gdiv_state_t            state_q;
   gdiv_state_t            state_d;
   logic [WIDTH-1:0]       n_q;
   logic [WIDTH-1:0]       d_q;
   logic [WIDTH-1:0]       k_q;
   logic [GDIV_IT_W-1:0]   it_q;
   logic                   err_pend_q;
   logic                   d_bad;
   logic                   last_iter;
   logic [WIDTH-1:0]       mul_a;
   logic [WIDTH-1:0]       mul_y;

   assign d_bad     = (d_in & ONE) == '0;
   assign last_iter = (it_q == IT_LAST);

   // Shared multiplier: N*K in MUL_N, D*K in MUL_D.
   assign mul_a = (state_q == MUL_D) ? d_q : n_q;

   gdiv_fxmul #(
      .WIDTH (WIDTH)
   ) u_fxmul (
      .a (mul_a),
      .b (k_q),
      .y (mul_y)
   );

   // ---- state register ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---- next-state logic ----
   // A rejected divisor parks in DONE for one extra cycle (err_pend_q) so
   // its result and done pulse appear two cycles after acceptance.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start) state_d = d_bad ? DONE : MUL_N;
            MUL_N:   state_d = MUL_D;
            MUL_D:   state_d = last_iter ? DONE : MUL_N;
            DONE:    state_d = err_pend_q ? DONE : IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // ---- outputs ----
   always_comb begin
      ready = (state_q == IDLE);
      done  = (state_q == DONE) && !err_pend_q;
   end

   // ---- datapath ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         n_q        <= '0;
         d_q        <= '0;
         k_q        <= '0;
         it_q       <= '0;
         q_out      <= '0;
         err        <= 1'b0;
         err_pend_q <= 1'b0;
      end else if (clear) begin
         // Abort: results from the previous divide stay visible.
         err_pend_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (d_bad) begin
                     err_pend_q <= 1'b1;
                  end else begin
                     n_q  <= n_in;
                     d_q  <= d_in;
                     k_q  <= ia_in;
                     it_q <= '0;
                     err  <= 1'b0;
                  end
               end
            end
            MUL_N: begin
               n_q <= mul_y;
            end
            MUL_D: begin
               d_q <= mul_y;
               // 2.0 - D: two's complement of D in WIDTH bits.
               k_q <= '0 - mul_y;
               if (last_iter) begin
                  q_out <= n_q;
               end else begin
                  it_q <= it_q + GDIV_IT_W'(1);
               end
            end
            DONE: begin
               if (err_pend_q) begin
                  q_out      <= {WIDTH{1'b1}};
                  err        <= 1'b1;
                  err_pend_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_goldschmidt_div.sv
module tb_goldschmidt_div;

   localparam int W     = 16;
   localparam int ITERS = 3;
   localparam int LAT   = 2 * (ITERS + 1) + 1;
   localparam int ELAT  = 2;

   logic         clk;
   logic         reset;
   logic         start;
   logic [W-1:0] n_in;
   logic [W-1:0] d_in;
   logic [W-1:0] ia_in;
   logic         clear;
   logic         ready;
   logic         done;
   logic [W-1:0] q_out;
   logic         err;

   typedef struct {
      logic [W-1:0] q;
      int           tol;
      logic         e;
      string        name;
   } exp_t;

   exp_t sb[$];
   int   n_tests  = 0;
   int   n_fail   = 0;
   int   done_cnt = 0;

   goldschmidt_div #(
      .WIDTH (W),
      .ITERS (ITERS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .n_in  (n_in),
      .d_in  (d_in),
      .ia_in (ia_in),
      .clear (clear),
      .ready (ready),
      .done  (done),
      .q_out (q_out),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push(input logic [W-1:0] q, input int tol, input logic e, input string name);
      exp_t x;
      x.q = q; x.tol = tol; x.e = e; x.name = name;
      sb.push_back(x);
   endtask

   // Scoreboard monitor: every done pulse consumes one expectation.
   always @(negedge clk) begin : monitor
      exp_t x;
      int   diff;
      if (reset === 1'b1 && done === 1'b1) begin
         done_cnt++;
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done with q_out=0x%0h, expected no done", q_out);
         end else begin
            x    = sb.pop_front();
            diff = int'(q_out) - int'(x.q);
            if (diff < 0) diff = -diff;
            n_tests++;
            if (diff > x.tol) begin
               n_fail++;
               $display("FAIL %s_q: got 0x%0h, expected 0x%0h +/- %0d", x.name, q_out, x.q, x.tol);
            end
            check({x.name, "_err"}, 32'(err), 32'(x.e));
         end
      end
   end

   // Waits (bounded) for ready, then presents one request and returns just
   // after the accepting edge.  With hold=1 start stays asserted.
   task automatic issue(input logic [W-1:0] n, input logic [W-1:0] d,
                        input logic [W-1:0] ia, input bit hold);
      int k = 0;
      @(negedge clk);
      while (ready !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (ready !== 1'b1) check("ready_timeout", 32'(ready), 32'd1);
      n_in  = n;
      d_in  = d;
      ia_in = ia;
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int exp_lat);
      int lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (done !== 1'b1 && lat < 40);
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
   endtask

   initial begin : stim
      int seen;
      int cnt0;
      reset = 1'b0;
      start = 1'b0;
      clear = 1'b0;
      n_in  = '0;
      d_in  = '0;
      ia_in = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_done",  32'(done),  32'd0);
      check("rst_q",     32'(q_out), 32'd0);
      check("rst_err",   32'(err),   32'd0);
      reset = 1'b1;

      // 1.0 / 1.0 with an exact seed
      push(16'h8000, 0, 1'b0, "one_by_one");
      issue(16'h8000, 16'h8000, 16'h8000, 1'b0);
      wait_done("one_by_one", LAT);

      // 1.04607 / 1.98315
      push(16'h4385, 2, 1'b0, "generic");
      issue(16'h85E5, 16'hFDD8, 16'h408B, 1'b0);
      wait_done("generic", LAT);

      // 1.5 / 1.0
      push(16'hC000, 0, 1'b0, "three_halves");
      issue(16'hC000, 16'h8000, 16'h8000, 1'b0);
      wait_done("three_halves", LAT);

      // 1.0 / 1.5 -> 2/3
      push(16'h5555, 0, 1'b0, "two_thirds");
      issue(16'h8000, 16'hC000, 16'h5555, 1'b0);
      wait_done("two_thirds", LAT);

      // non-normalised divisors
      push(16'hFFFF, 0, 1'b1, "d_zero");
      issue(16'h8000, 16'h0000, 16'h8000, 1'b0);
      wait_done("d_zero", ELAT);
      push(16'hFFFF, 0, 1'b1, "d_7fff");
      issue(16'h8000, 16'h7FFF, 16'h8000, 1'b0);
      wait_done("d_7fff", ELAT);

      // a valid divide clears err
      push(16'h8000, 0, 1'b0, "err_clear");
      issue(16'h8000, 16'h8000, 16'h8000, 1'b0);
      wait_done("err_clear", LAT);

      // start held high through a divide, then back-to-back request
      cnt0 = done_cnt;
      push(16'hC000, 0, 1'b0, "hammer_a");
      issue(16'hC000, 16'h8000, 16'h8000, 1'b1);
      n_in = 16'h8000;
      d_in = 16'h0000;
      wait_done("hammer_a", LAT);
      n_in  = 16'h8000;
      d_in  = 16'hC000;
      ia_in = 16'h5555;
      push(16'h5555, 0, 1'b0, "hammer_b");
      @(negedge clk);
      check("b2b_ready", 32'(ready), 32'd1);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("hammer_b", LAT);
      check("hammer_done_count", 32'(done_cnt - cnt0), 32'd2);

      // clear during MUL_D of iteration 1
      issue(16'hC000, 16'h8000, 16'h8000, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      check("clr_ready", 32'(ready), 32'd1);
      check("clr_q_kept", 32'(q_out), 32'h5555);
      check("clr_err_kept", 32'(err), 32'd0);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      check("clr_no_done", 32'(seen), 32'd0);

      // asynchronous reset in the middle of a divide
      issue(16'hC000, 16'h8000, 16'h8000, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("arst_ready", 32'(ready), 32'd1);
      check("arst_done",  32'(done),  32'd0);
      check("arst_q",     32'(q_out), 32'd0);
      check("arst_err",   32'(err),   32'd0);
      @(negedge clk);
      reset = 1'b1;

      push(16'h8000, 1, 1'b0, "post_reset");
      issue(16'hC000, 16'hC000, 16'h5555, 1'b0);
      wait_done("post_reset", LAT);

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no end of stimulus, expected finish before 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
